// File: rtl/sa_matmul_seq.sv
// Control sequencer for a weight-stationary systolic array: weight load, skewed
// activation streaming, skewed output write-back, with reuse and accumulate modes.
module sa_matmul_seq #(
  parameter int NUM_ROWS = 4,
  parameter int NUM_COLS = 4,
  parameter int MAX_M    = 16,
  parameter int M_W      = $clog2(MAX_M + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_start,
  input  logic [M_W-1:0]               i_m_len,
  input  logic                         i_reuse_w,
  input  logic                         i_acc_mode,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_err,
  output logic                         o_w_valid,
  output logic                         o_w_rd_en,
  output logic [$clog2(NUM_ROWS)-1:0]  o_w_rd_addr,
  output logic                         o_load_w,
  output logic [NUM_ROWS-1:0]          o_in_rd_en,
  output logic [NUM_ROWS*M_W-1:0]      o_in_rd_addr,
  output logic [NUM_ROWS-1:0]          o_act_valid,
  output logic [NUM_COLS-1:0]          o_out_wr_en,
  output logic [NUM_COLS*M_W-1:0]      o_out_wr_addr,
  output logic                         o_out_acc
);

  localparam int WA_W = $clog2(NUM_ROWS);
  localparam int T_W  = $clog2(MAX_M + NUM_ROWS + NUM_COLS + 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLoadW  = 2'd1;
  localparam logic [1:0] StStream = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [T_W-1:0]      t_q, t_d;
  logic [M_W-1:0]      m_len_q, m_len_d;
  logic                acc_q, acc_d;
  logic                w_valid_q, w_valid_d;
  logic                err_q, err_d;
  logic [NUM_ROWS-1:0] act_valid_q;
  logic                start_bad;
  int                  t_i, m_i;

  assign t_i = int'(t_q);
  assign m_i = int'(m_len_q);

  assign start_bad = (i_m_len == '0) || (int'(i_m_len) > MAX_M) || (i_reuse_w && !w_valid_q);

  always_comb begin
    state_d   = state_q;
    t_d       = t_q + T_W'(1);
    m_len_d   = m_len_q;
    acc_d     = acc_q;
    w_valid_d = w_valid_q;
    err_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        t_d = '0;
        if (i_start) begin
          if (start_bad) begin
            err_d = 1'b1;
          end else begin
            m_len_d = i_m_len;
            acc_d   = i_acc_mode;
            if (i_reuse_w) begin
              state_d = StStream;
            end else begin
              state_d   = StLoadW;
              w_valid_d = 1'b0;
            end
          end
        end
      end
      StLoadW: begin
        if (t_q == T_W'(NUM_ROWS)) begin
          state_d   = StStream;
          t_d       = '0;
          w_valid_d = 1'b1;
        end
      end
      StStream: begin
        if (t_i == m_i + NUM_ROWS + NUM_COLS - 1) begin
          state_d = StDone;
          t_d     = '0;
        end
      end
      default: begin
        state_d = StIdle;
        t_d     = '0;
      end
    endcase
  end

  // Memory-side strobes are decoded from (state, t) so they never see the inputs.
  always_comb begin
    o_w_rd_en     = 1'b0;
    o_w_rd_addr   = '0;
    o_load_w      = 1'b0;
    o_in_rd_en    = '0;
    o_in_rd_addr  = '0;
    o_out_wr_en   = '0;
    o_out_wr_addr = '0;
    if (state_q == StLoadW) begin
      if (t_i < NUM_ROWS) begin
        o_w_rd_en   = 1'b1;
        o_w_rd_addr = WA_W'(NUM_ROWS - 1 - t_i);
      end
      o_load_w = (t_i >= 1);
    end
    if (state_q == StStream) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (t_i >= r && t_i < r + m_i) begin
          o_in_rd_en[r]               = 1'b1;
          o_in_rd_addr[r*M_W +: M_W] = M_W'(t_i - r);
        end
      end
      // One PE hop per column plus the input read latency ahead of the first row.
      for (int c = 0; c < NUM_COLS; c++) begin
        if (t_i >= NUM_ROWS + c + 1 && t_i < NUM_ROWS + c + 1 + m_i) begin
          o_out_wr_en[c]              = 1'b1;
          o_out_wr_addr[c*M_W +: M_W] = M_W'(t_i - NUM_ROWS - c - 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      t_q         <= '0;
      m_len_q     <= '0;
      acc_q       <= 1'b0;
      w_valid_q   <= 1'b0;
      err_q       <= 1'b0;
      act_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      m_len_q     <= m_len_d;
      acc_q       <= acc_d;
      w_valid_q   <= w_valid_d;
      err_q       <= err_d;
      act_valid_q <= o_in_rd_en;
    end
  end

  assign o_busy      = (state_q == StLoadW) || (state_q == StStream);
  assign o_done      = (state_q == StDone);
  assign o_err       = err_q;
  assign o_w_valid   = w_valid_q;
  assign o_act_valid = act_valid_q;
  assign o_out_acc   = acc_q;

endmodule

// File: tb/tb_sa_matmul_seq.sv
// Scoreboard bench for sa_matmul_seq: expected strobe events are derived from the
// job timing formulas at start time and matched against what the DUT emits.
module tb_sa_matmul_seq;

  localparam int R    = 4;
  localparam int C    = 4;
  localparam int MAXM = 16;
  localparam int M_W  = $clog2(MAXM + 1);
  localparam int WA_W = $clog2(R);

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              i_start = 1'b0;
  logic [M_W-1:0]    i_m_len = '0;
  logic              i_reuse_w = 1'b0;
  logic              i_acc_mode = 1'b0;
  logic              o_busy, o_done, o_err, o_w_valid, o_w_rd_en, o_load_w, o_out_acc;
  logic [WA_W-1:0]   o_w_rd_addr;
  logic [R-1:0]      o_in_rd_en, o_act_valid;
  logic [R*M_W-1:0]  o_in_rd_addr;
  logic [C-1:0]      o_out_wr_en;
  logic [C*M_W-1:0]  o_out_wr_addr;

  int                n_checks = 0;
  int                n_err = 0;
  int                cyc = 0;
  bit                model_wv = 1'b0;
  logic [63:0]       q[$];

  sa_matmul_seq #(.NUM_ROWS(R), .NUM_COLS(C), .MAX_M(MAXM)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_m_len(i_m_len),
    .i_reuse_w(i_reuse_w), .i_acc_mode(i_acc_mode), .o_busy(o_busy), .o_done(o_done),
    .o_err(o_err), .o_w_valid(o_w_valid), .o_w_rd_en(o_w_rd_en), .o_w_rd_addr(o_w_rd_addr),
    .o_load_w(o_load_w), .o_in_rd_en(o_in_rd_en), .o_in_rd_addr(o_in_rd_addr),
    .o_act_valid(o_act_valid), .o_out_wr_en(o_out_wr_en), .o_out_wr_addr(o_out_wr_addr),
    .o_out_acc(o_out_acc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event kinds: 0 w_rd, 1 load_w, 2 in_rd, 3 act_valid, 4 out_wr, 5 done, 6 busy, 7 err
  function automatic logic [63:0] ev(input int c, input int k, input int i, input int a,
                                     input int x);
    ev = {c[31:0], k[3:0], i[7:0], a[15:0], x[3:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic obs(input logic [63:0] v);
    logic [63:0] e;
    e = (q.size() > 0) ? q.pop_front() : '1;
    chk("event", v, e);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_w_rd_en) obs(ev(cyc, 0, 0, int'(o_w_rd_addr), 0));
      if (o_load_w) obs(ev(cyc, 1, 0, 0, 0));
      for (int r = 0; r < R; r++)
        if (o_in_rd_en[r]) obs(ev(cyc, 2, r, int'(o_in_rd_addr[r*M_W +: M_W]), 0));
      for (int r = 0; r < R; r++)
        if (o_act_valid[r]) obs(ev(cyc, 3, r, 0, 0));
      for (int c = 0; c < C; c++)
        if (o_out_wr_en[c])
          obs(ev(cyc, 4, c, int'(o_out_wr_addr[c*M_W +: M_W]), int'(o_out_acc)));
      if (o_done) obs(ev(cyc, 5, 0, 0, 0));
      if (o_busy) obs(ev(cyc, 6, 0, 0, 0));
      if (o_err) obs(ev(cyc, 7, 0, 0, 0));
    end
  end

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a start for one cycle and queue everything the job should produce.
  task automatic start_job(input int m, input bit reuse, input bit acc, output int s,
                           output int d);
    int base, lw, st;
    bit bad;
    i_start    = 1'b1;
    i_m_len    = M_W'(m);
    i_reuse_w  = reuse;
    i_acc_mode = acc;
    s   = cyc;
    bad = (m == 0) || (m > MAXM) || (reuse && !model_wv);
    if (bad) begin
      q.push_back(ev(s + 1, 7, 0, 0, 0));
      d = s + 1;
    end else begin
      d    = reuse ? s + m + R + C + 1 : s + 2 * R + m + C + 2;
      base = reuse ? s + 1 : s + R + 2;
      if (!reuse) model_wv = 1'b1;
      for (int cy = s + 1; cy <= d; cy++) begin
        lw = cy - (s + 1);
        st = cy - base;
        if (!reuse && lw >= 0 && lw < R) q.push_back(ev(cy, 0, 0, R - 1 - lw, 0));
        if (!reuse && lw >= 1 && lw <= R) q.push_back(ev(cy, 1, 0, 0, 0));
        for (int r = 0; r < R; r++)
          if (st >= r && st < r + m) q.push_back(ev(cy, 2, r, st - r, 0));
        for (int r = 0; r < R; r++)
          if (st - 1 >= r && st - 1 < r + m) q.push_back(ev(cy, 3, r, 0, 0));
        for (int c = 0; c < C; c++)
          if (st >= R + c + 1 && st < R + c + 1 + m)
            q.push_back(ev(cy, 4, c, st - R - c - 1, int'(acc)));
        if (cy == d) q.push_back(ev(cy, 5, 0, 0, 0));
        else q.push_back(ev(cy, 6, 0, 0, 0));
      end
    end
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic drain(input string tag, input int d);
    wait_until(d + 2);
    chk(tag, 64'(q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, d, s2, d2;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_err", 64'(o_err), 64'd0);
    chk("rst_w_valid", 64'(o_w_valid), 64'd0);
    chk("rst_w_rd_en", 64'(o_w_rd_en), 64'd0);
    chk("rst_load_w", 64'(o_load_w), 64'd0);
    chk("rst_in_rd_en", 64'(o_in_rd_en), 64'd0);
    chk("rst_act_valid", 64'(o_act_valid), 64'd0);
    chk("rst_out_wr_en", 64'(o_out_wr_en), 64'd0);
    chk("rst_out_acc", 64'(o_out_acc), 64'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Rejected starts
    start_job(3, 1'b1, 1'b0, s, d);
    drain("rej_reuse", d);
    start_job(0, 1'b0, 1'b0, s, d);
    drain("rej_zero", d);
    start_job(17, 1'b0, 1'b0, s, d);
    drain("rej_over", d);
    chk("wv_after_rej", 64'(o_w_valid), 64'd0);

    // Full job M=3
    start_job(3, 1'b0, 1'b0, s, d);
    drain("full_m3", d);
    chk("wv_after_full", 64'(o_w_valid), 64'd1);
    chk("idle_in_addr", 64'(o_in_rd_addr), 64'd0);
    chk("idle_out_addr", 64'(o_out_wr_addr), 64'd0);

    // Reuse with accumulate
    start_job(2, 1'b1, 1'b1, s, d);
    drain("reuse_acc_m2", d);

    // Start while busy is ignored
    start_job(5, 1'b1, 1'b0, s, d);
    wait_until(s + 4);
    i_start   = 1'b1;
    i_m_len   = '0;
    i_reuse_w = 1'b0;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    drain("busy_start", d);
    chk("wv_after_busy_start", 64'(o_w_valid), 64'd1);

    // Back-to-back: start in DONE ignored, first IDLE cycle accepted; M=1 boundary
    start_job(1, 1'b0, 1'b0, s, d);
    wait_until(d);
    i_start    = 1'b1;
    i_m_len    = M_W'(1);
    i_reuse_w  = 1'b1;
    i_acc_mode = 1'b1;
    @(posedge clk);
    #1;
    start_job(1, 1'b1, 1'b1, s2, d2);
    drain("b2b_m1", d2);

    // M=MAX_M boundary with accumulate
    start_job(MAXM, 1'b0, 1'b1, s, d);
    wait_until(s + 2);
    chk("wv_in_loadw", 64'(o_w_valid), 64'd0);
    drain("full_m16", d);
    chk("wv_after_m16", 64'(o_w_valid), 64'd1);

    // Reset mid-STREAM at t=5
    start_job(4, 1'b0, 1'b0, s, d);
    wait_until(s + R + 2 + 5);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_rd_en", 64'(o_in_rd_en), 64'd0);
    chk("mid_rst_act_valid", 64'(o_act_valid), 64'd0);
    chk("mid_rst_out_wr_en", 64'(o_out_wr_en), 64'd0);
    chk("mid_rst_w_valid", 64'(o_w_valid), 64'd0);
    chk("mid_rst_busy", 64'(o_busy), 64'd0);
    q.delete();
    model_wv = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    drain("no_done_after_rst", d);
    start_job(2, 1'b1, 1'b0, s, d);
    drain("rej_after_rst", d);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
